decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  ID stage of the pipelined CPU, directly upstream of the ALU (EX stage).
//  Decodes the IF instruction, reads/bypasses Ra/Rb, maps opcode to the 6-bit ALU FN
//  and registers {A, B, FN, Rc, wen} into the ID/EX pipeline register.
//  Owns the 32x32 register file (WB write port) and the load-use stall.
// PARAMETERS
//  XLEN    32  datapath width
//  NREG    32  architectural registers; R31 reads 0, writes to R31 ignored
// PORTS
//  clk         in   1     clock, all state on rising edge
//  n_rst       in   1     reset, asynchronous, active-low
//  if_valid    in   1     if_instr holds a valid instruction
//  if_instr    in   32    [31:26] op, [25:21] Rc, [20:16] Ra, [15:11] Rb, [15:0] lit
//  id_stall    out  1     hold IF (combinational, load-use hazard)
//  ex_is_ld    in   1     instruction now in EX is a load
//  ex_rc       in   5     EX destination; ex_wen in 1 EX writes Rc; ex_y in 32 ALU result
//  mem_rc      in   5     MEM destination; mem_wen in 1; mem_y in 32 MEM result
//  wb_rc       in   5     WB destination; wb_wen in 1; wb_y in 32 WB data (RF write)
//  ex_valid    out  1     ID/EX register valid
//  alu_a       out  32    registered operand A
//  alu_b       out  32    registered operand B (Rb value or sext literal)
//  alu_fn      out  6     registered ALU FN
//  ex_rc_o     out  5     registered destination; ex_wen_o out 1 registered write enable
//  illegal     out  1     registered, 1-cycle pulse: undecodable op was accepted
// BEHAVIOUR
//  Reset (n_rst=0, async): ex_valid=0, alu_a=alu_b=0, alu_fn=6'b010000 (ADD),
//   ex_rc_o=5'd31, ex_wen_o=0, illegal=0; all 32 RF entries cleared to 0.
//  Latency: 1 cycle, instruction at IF edge k appears on alu_* after edge k.
//  Decode: op[5:4]=10 reg-reg (B=Rb), 11 literal (B=sext(lit)); other op[5:4] not ALU.
//   op[3:0] -> FN: 0000 ADD 010000, 0001 SUB 010001, 0100 CMPEQ 000011,
//   0101 CMPLT 000101, 0110 CMPLE 000111, 1000 AND 101000, 1001 OR 101110,
//   1010 XOR 100110, 1100 SHL 110000, 1101 SHR 110001, 1110 SRA 110011.
//   Any other op: illegal -> bubble (ex_valid=0, ex_wen_o=0), illegal=1 for 1 cycle.
//  Operand select, priority per source reg r (Ra, and Rb when reg-reg):
//   r==31 -> 0; EX match (ex_wen && ex_rc==r && !ex_is_ld) -> ex_y;
//   MEM match -> mem_y; WB match -> wb_y (write-through); else RF[r].
//   Matches against Rc==31 never bypass.
//  Load-use: ex_is_ld && ex_wen && ex_rc==used src && ex_rc!=31 && if_valid
//   -> id_stall=1, ID/EX loads a bubble, IF instruction held and re-decoded next cycle.
//  if_valid=0 -> bubble. Bubble: ex_valid=0, ex_wen_o=0, alu_* don't-care but stable.
//  RF write: on edge when wb_wen && wb_rc!=31; same-cycle read sees new value (bypass).
//  Reset mid-operation: ID/EX cleared immediately; stall drops with reset.
//  Simultaneous EX+MEM+WB match on same r: EX wins.
// STRUCTURE
//  Package cpu_pkg: alu_fn_t enum (12 FN codes), op[3:0] constants, XLEN, R31 index.
//  Sub-module regfile (2 async read, 1 sync write, async active-low reset); the rest
//  (decoder, bypass muxes, hazard logic, ID/EX register) lives in decode_stage.
// TESTING
//  Reset: n_rst=0 mid-run -> ex_valid=0, alu_fn=010000, ex_rc_o=31 same cycle.
//  WB R1=5 then ADDC R2,R1,-100 (op 110000, lit 0xFF9C) -> alu_a=5, alu_b=-100, fn=010000.
//  SUB R3,R1,R1 with EX writing R1=7, MEM writing R1=9 -> alu_a=alu_b=7 (EX priority).
//  Load into R4 in EX, next instr uses R4 -> id_stall=1 one cycle, bubble, then reissue.
//  Operand R31 with ex_rc=31, ex_wen=1, ex_y=0xDEAD -> operand 0, no bypass.
//  op 011011 (XNOR) -> illegal=1 one cycle, ex_valid=0; following SRA decodes 110011.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared decode definitions for the CPU pipeline: ALU function codes, opcode
// low-nibble constants and architectural sizes.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam logic [4:0] R31 = 5'd31;

    // op[5:4] instruction class
    localparam logic [1:0] CLS_RR  = 2'b10;
    localparam logic [1:0] CLS_LIT = 2'b11;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_CMPEQ = 4'b0100;
    localparam logic [3:0] OP_CMPLT = 4'b0101;
    localparam logic [3:0] OP_CMPLE = 4'b0110;
    localparam logic [3:0] OP_AND   = 4'b1000;
    localparam logic [3:0] OP_OR    = 4'b1001;
    localparam logic [3:0] OP_XOR   = 4'b1010;
    localparam logic [3:0] OP_SHL   = 4'b1100;
    localparam logic [3:0] OP_SHR   = 4'b1101;
    localparam logic [3:0] OP_SRA   = 4'b1110;

    // FN_NOP is the filler code carried by undecodable ops; it never reaches EX as valid.
    typedef enum logic [5:0] {
        FN_NOP   = 6'b000000,
        FN_ADD   = 6'b010000,
        FN_SUB   = 6'b010001,
        FN_CMPEQ = 6'b000011,
        FN_CMPLT = 6'b000101,
        FN_CMPLE = 6'b000111,
        FN_AND   = 6'b101000,
        FN_OR    = 6'b101110,
        FN_XOR   = 6'b100110,
        FN_SHL   = 6'b110000,
        FN_SHR   = 6'b110001,
        FN_SRA   = 6'b110011
    } alu_fn_t;

    typedef struct packed {
        logic    legal;
        alu_fn_t fn;
    } fn_dec_t;

    function automatic fn_dec_t decode_fn(input logic [3:0] f);
        fn_dec_t d;
        d.legal = 1'b1;
        d.fn    = FN_NOP;
        case (f)
            OP_ADD:   d.fn = FN_ADD;
            OP_SUB:   d.fn = FN_SUB;
            OP_CMPEQ: d.fn = FN_CMPEQ;
            OP_CMPLT: d.fn = FN_CMPLT;
            OP_CMPLE: d.fn = FN_CMPLE;
            OP_AND:   d.fn = FN_AND;
            OP_OR:    d.fn = FN_OR;
            OP_XOR:   d.fn = FN_XOR;
            OP_SHL:   d.fn = FN_SHL;
            OP_SHR:   d.fn = FN_SHR;
            OP_SRA:   d.fn = FN_SRA;
            default:  d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/regfile.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port; the top register is hardwired and never written.
module regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic [AW-1:0]   ra_addr,
    input  logic [AW-1:0]   rb_addr,
    output logic [XLEN-1:0] ra_data,
    output logic [XLEN-1:0] rb_data,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd
);

    logic [XLEN-1:0] mem [NREG];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (we && wa != AW'(NREG - 1)) begin
            mem[wa] <= wd;
        end
    end

    assign ra_data = mem[ra_addr];
    assign rb_data = mem[rb_addr];

endmodule

// File: rtl/decode_stage.sv
// ID stage: decodes the fetched instruction, resolves operands through the
// EX/MEM/WB bypass network, detects load-use hazards and fills the ID/EX register.
module decode_stage
    import cpu_pkg::*;
#(
    parameter int XLEN = cpu_pkg::XLEN,
    parameter int NREG = cpu_pkg::NREG
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    output logic            id_stall,
    input  logic            ex_is_ld,
    input  logic [4:0]      ex_rc,
    input  logic            ex_wen,
    input  logic [XLEN-1:0] ex_y,
    input  logic [4:0]      mem_rc,
    input  logic            mem_wen,
    input  logic [XLEN-1:0] mem_y,
    input  logic [4:0]      wb_rc,
    input  logic            wb_wen,
    input  logic [XLEN-1:0] wb_y,
    output logic            ex_valid,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [5:0]      alu_fn,
    output logic [4:0]      ex_rc_o,
    output logic            ex_wen_o,
    output logic            illegal
);

    logic [5:0]  op;
    logic [4:0]  rc, ra, rb;
    logic [15:0] lit;

    assign op  = if_instr[31:26];
    assign rc  = if_instr[25:21];
    assign ra  = if_instr[20:16];
    assign rb  = if_instr[15:11];
    assign lit = if_instr[15:0];

    fn_dec_t dec;
    logic    alu_op, reg_reg;

    assign dec     = decode_fn(op[3:0]);
    assign reg_reg = (op[5:4] == CLS_RR);
    assign alu_op  = (reg_reg || op[5:4] == CLS_LIT) && dec.legal;

    logic [XLEN-1:0] rf_a, rf_b;

    regfile #(.XLEN(XLEN), .NREG(NREG), .AW(5)) u_rf (
        .clk     (clk),
        .n_rst   (n_rst),
        .ra_addr (ra),
        .rb_addr (rb),
        .ra_data (rf_a),
        .rb_data (rf_b),
        .we      (wb_wen),
        .wa      (wb_rc),
        .wd      (wb_y)
    );

    // Youngest producer wins; a load in EX has no data yet and is handled by the stall.
    function automatic logic [XLEN-1:0] pick_src(
        input logic [4:0]      r,
        input logic [XLEN-1:0] rf_val,
        input logic            e_fwd,
        input logic [4:0]      e_rc,
        input logic [XLEN-1:0] e_y,
        input logic            m_wen,
        input logic [4:0]      m_rc,
        input logic [XLEN-1:0] m_y,
        input logic            w_wen,
        input logic [4:0]      w_rc,
        input logic [XLEN-1:0] w_y
    );
        if (r == R31)                   return '0;
        else if (e_fwd && e_rc == r)    return e_y;
        else if (m_wen && m_rc == r)    return m_y;
        else if (w_wen && w_rc == r)    return w_y;
        else                            return rf_val;
    endfunction

    logic                   ex_fwd;
    logic [XLEN-1:0]        opa, rb_val, opb;
    logic signed [XLEN-1:0] lit_sext;

    assign ex_fwd   = ex_wen && !ex_is_ld;
    assign lit_sext = {{(XLEN-16){lit[15]}}, lit};
    assign opa      = pick_src(ra, rf_a, ex_fwd, ex_rc, ex_y, mem_wen, mem_rc, mem_y,
                               wb_wen, wb_rc, wb_y);
    assign rb_val   = pick_src(rb, rf_b, ex_fwd, ex_rc, ex_y, mem_wen, mem_rc, mem_y,
                               wb_wen, wb_rc, wb_y);
    assign opb      = reg_reg ? rb_val : lit_sext;

    logic ld_pending, hazard, issue;

    assign ld_pending = ex_is_ld && ex_wen && ex_rc != R31;
    assign hazard     = if_valid && alu_op && ld_pending &&
                        (ex_rc == ra || (reg_reg && ex_rc == rb));
    assign id_stall   = hazard && n_rst;
    assign issue      = if_valid && alu_op && !hazard;

    logic            vld_p1, wen_p1, illegal_p1;
    logic [XLEN-1:0] a_p1, b_p1;
    alu_fn_t         fn_p1;
    logic [4:0]      rc_p1;

    // ID -> EX boundary; payload only moves on issue so bubbles leave it stable
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vld_p1     <= 1'b0;
            wen_p1     <= 1'b0;
            illegal_p1 <= 1'b0;
            a_p1       <= '0;
            b_p1       <= '0;
            fn_p1      <= FN_ADD;
            rc_p1      <= R31;
        end else begin
            vld_p1     <= issue;
            wen_p1     <= issue;
            illegal_p1 <= if_valid && !alu_op;
            if (issue) begin
                a_p1  <= opa;
                b_p1  <= opb;
                fn_p1 <= dec.fn;
                rc_p1 <= rc;
            end
        end
    end

    assign ex_valid = vld_p1;
    assign ex_wen_o = wen_p1;
    assign illegal  = illegal_p1;
    assign alu_a    = a_p1;
    assign alu_b    = b_p1;
    assign alu_fn   = fn_p1;
    assign ex_rc_o  = rc_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus randomized traffic checked
// against a behavioural model of the decode rules and register file.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        if_valid;
    logic [31:0] if_instr;
    logic        id_stall;
    logic        ex_is_ld, ex_wen, mem_wen, wb_wen;
    logic [4:0]  ex_rc, mem_rc, wb_rc;
    logic [31:0] ex_y, mem_y, wb_y;
    logic        ex_valid, ex_wen_o, illegal;
    logic [31:0] alu_a, alu_b;
    logic [5:0]  alu_fn;
    logic [4:0]  ex_rc_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .n_rst(n_rst), .if_valid(if_valid), .if_instr(if_instr),
        .id_stall(id_stall), .ex_is_ld(ex_is_ld), .ex_rc(ex_rc), .ex_wen(ex_wen),
        .ex_y(ex_y), .mem_rc(mem_rc), .mem_wen(mem_wen), .mem_y(mem_y),
        .wb_rc(wb_rc), .wb_wen(wb_wen), .wb_y(wb_y), .ex_valid(ex_valid),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fn(alu_fn), .ex_rc_o(ex_rc_o),
        .ex_wen_o(ex_wen_o), .illegal(illegal)
    );

    // ---------------- reference model ----------------
    logic [31:0] rf_m [32];
    logic        e_valid, e_wen, e_illegal;
    logic [31:0] e_a, e_b;
    logic [5:0]  e_fn;
    logic [4:0]  e_rc;
    logic        p_valid, p_illegal, p_stall;
    logic [31:0] p_a, p_b;
    logic [5:0]  p_fn;
    logic [4:0]  p_rc;

    logic [3:0] fcodes [11] = '{4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hC, 4'hD, 4'hE};

    function automatic logic [5:0] ref_fn(input logic [3:0] f, output logic ok);
        ok = 1'b1;
        case (f)
            4'h0: return 6'b010000;
            4'h1: return 6'b010001;
            4'h4: return 6'b000011;
            4'h5: return 6'b000101;
            4'h6: return 6'b000111;
            4'h8: return 6'b101000;
            4'h9: return 6'b101110;
            4'hA: return 6'b100110;
            4'hC: return 6'b110000;
            4'hD: return 6'b110001;
            4'hE: return 6'b110011;
            default: begin ok = 1'b0; return 6'b000000; end
        endcase
    endfunction

    function automatic logic [31:0] src_val(input logic [4:0] r);
        if (r == 5'd31) return 32'd0;
        if (ex_wen && !ex_is_ld && ex_rc == r) return ex_y;
        if (mem_wen && mem_rc == r) return mem_y;
        if (wb_wen && wb_rc == r) return wb_y;
        return rf_m[r];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
        e_valid = 0; e_wen = 0; e_illegal = 0;
        e_a = 0; e_b = 0; e_fn = 6'b010000; e_rc = 5'd31;
    endtask

    task automatic predict();
        logic [5:0] op;
        logic [5:0] f;
        logic ok, legal, rr, acc;
        logic [4:0] ra, rb;
        op = if_instr[31:26];
        ra = if_instr[20:16];
        rb = if_instr[15:11];
        f = ref_fn(op[3:0], ok);
        legal = op[5] && ok;
        rr = !op[4];
        p_stall = if_valid && legal && ex_is_ld && ex_wen && ex_rc != 5'd31 &&
                  (ex_rc == ra || (rr && ex_rc == rb));
        acc = if_valid && legal && !p_stall;
        p_valid = acc;
        p_illegal = if_valid && !legal;
        p_a  = acc ? src_val(ra) : e_a;
        p_b  = acc ? (rr ? src_val(rb) : {{16{if_instr[15]}}, if_instr[15:0]}) : e_b;
        p_fn = acc ? f : e_fn;
        p_rc = acc ? if_instr[25:21] : e_rc;
    endtask

    task automatic step();
        predict();
        @(posedge clk);
        e_valid = p_valid; e_wen = p_valid; e_illegal = p_illegal;
        e_a = p_a; e_b = p_b; e_fn = p_fn; e_rc = p_rc;
        if (wb_wen && wb_rc != 5'd31) rf_m[wb_rc] = wb_y;
        #1;
    endtask

    task automatic set_idle();
        if_valid = 0; if_instr = 0;
        ex_is_ld = 0; ex_wen = 0; ex_rc = 0; ex_y = 0;
        mem_wen = 0; mem_rc = 0; mem_y = 0;
        wb_wen = 0; wb_rc = 0; wb_y = 0;
    endtask

    function automatic logic [31:0] instr(input logic [5:0] op, input logic [4:0] rc,
                                          input logic [4:0] ra, input logic [15:0] low);
        return {op, rc, ra, low};
    endfunction

    function automatic logic [4:0] pick_reg();
        int k;
        k = $urandom_range(0, 4);
        return (k == 4) ? 5'd31 : 5'(k);
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        set_idle();
        n_rst = 0;
        model_reset();
        #12;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", ex_valid); end
        checks++; if (alu_fn !== 6'b010000) begin errors++; $display("FAIL reset_fn: got %b want 010000", alu_fn); end
        checks++; if (ex_rc_o !== 5'd31) begin errors++; $display("FAIL reset_rc: got %0d want 31", ex_rc_o); end
        checks++; if ({alu_a, alu_b} !== 64'd0) begin errors++; $display("FAIL reset_ab: got %h %h want 0 0", alu_a, alu_b); end
        checks++; if ({ex_wen_o, illegal} !== 2'b00) begin errors++; $display("FAIL reset_wen_ill: got %b want 00", {ex_wen_o, illegal}); end
        @(posedge clk); #1;
        n_rst = 1;
    endtask

    task automatic test_bypass_lit();
        set_idle();
        wb_wen = 1; wb_rc = 5'd1; wb_y = 32'd5;
        step();
        set_idle();
        if_valid = 1; if_instr = instr(6'b110000, 5'd2, 5'd1, 16'hFF9C);
        step();
        checks++; if (alu_a !== 32'd5) begin errors++; $display("FAIL addc_a: got %h want 5", alu_a); end
        checks++; if (alu_b !== 32'hFFFFFF9C) begin errors++; $display("FAIL addc_b: got %h want ffffff9c", alu_b); end
        checks++; if (alu_fn !== 6'b010000) begin errors++; $display("FAIL addc_fn: got %b want 010000", alu_fn); end
        checks++; if ({ex_valid, ex_wen_o, ex_rc_o} !== {2'b11, 5'd2}) begin errors++; $display("FAIL addc_ctl: got %b%b rc=%0d want 11 rc=2", ex_valid, ex_wen_o, ex_rc_o); end
    endtask

    task automatic test_ex_priority();
        set_idle();
        ex_wen = 1; ex_rc = 5'd1; ex_y = 32'd7;
        mem_wen = 1; mem_rc = 5'd1; mem_y = 32'd9;
        wb_wen = 1; wb_rc = 5'd1; wb_y = 32'd11;
        if_valid = 1; if_instr = instr(6'b100001, 5'd3, 5'd1, {5'd1, 11'd0});
        step();
        checks++; if (alu_a !== 32'd7 || alu_b !== 32'd7) begin errors++; $display("FAIL ex_prio: got %h %h want 7 7", alu_a, alu_b); end
        checks++; if (alu_fn !== 6'b010001) begin errors++; $display("FAIL sub_fn: got %b want 010001", alu_fn); end
    endtask

    task automatic test_load_use();
        logic [31:0] held_a;
        set_idle();
        ex_is_ld = 1; ex_wen = 1; ex_rc = 5'd4;
        if_valid = 1; if_instr = instr(6'b100000, 5'd5, 5'd4, {5'd0, 11'd0});
        #1;
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL ld_stall: got %0b want 1", id_stall); end
        held_a = alu_a;
        step();
        checks++; if ({ex_valid, ex_wen_o} !== 2'b00) begin errors++; $display("FAIL ld_bubble: got %b want 00", {ex_valid, ex_wen_o}); end
        checks++; if (alu_a !== held_a) begin errors++; $display("FAIL ld_stable: got %h want %h", alu_a, held_a); end
        ex_is_ld = 0; ex_wen = 0; ex_rc = 0;
        mem_wen = 1; mem_rc = 5'd4; mem_y = 32'h1234;
        #1;
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL ld_release: got %0b want 0", id_stall); end
        step();
        checks++; if (ex_valid !== 1'b1 || alu_a !== 32'h1234 || ex_rc_o !== 5'd5) begin errors++; $display("FAIL ld_reissue: got v=%0b a=%h rc=%0d want v=1 a=1234 rc=5", ex_valid, alu_a, ex_rc_o); end
        checks++; if (alu_b !== rf_m[0]) begin errors++; $display("FAIL ld_reissue_b: got %h want %h", alu_b, rf_m[0]); end
    endtask

    task automatic test_r31();
        set_idle();
        ex_wen = 1; ex_rc = 5'd31; ex_y = 32'hDEAD;
        mem_wen = 1; mem_rc = 5'd31; mem_y = 32'hBEEF;
        if_valid = 1; if_instr = instr(6'b100000, 5'd6, 5'd31, {5'd31, 11'd0});
        step();
        checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0) begin errors++; $display("FAIL r31_operand: got %h %h want 0 0", alu_a, alu_b); end
        ex_is_ld = 1;
        #1;
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL r31_nostall: got %0b want 0", id_stall); end
        step();
    endtask

    task automatic test_illegal();
        set_idle();
        if_valid = 1; if_instr = instr(6'b011011, 5'd7, 5'd1, 16'd0);
        step();
        checks++; if (illegal !== 1'b1 || ex_valid !== 1'b0 || ex_wen_o !== 1'b0) begin errors++; $display("FAIL xnor_illegal: got ill=%0b v=%0b w=%0b want 1 0 0", illegal, ex_valid, ex_wen_o); end
        if_instr = instr(6'b101110, 5'd8, 5'd1, {5'd2, 11'd0});
        step();
        checks++; if (illegal !== 1'b0 || ex_valid !== 1'b1 || alu_fn !== 6'b110011) begin errors++; $display("FAIL sra_after: got ill=%0b v=%0b fn=%b want 0 1 110011", illegal, ex_valid, alu_fn); end
        if_instr = instr(6'b111111, 5'd8, 5'd1, 16'd0);
        step();
        set_idle();
        step();
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_pulse: got %0b want 0", illegal); end
    endtask

    task automatic test_reset_mid();
        set_idle();
        if_valid = 1; if_instr = instr(6'b101000, 5'd9, 5'd1, {5'd2, 11'd0});
        step();
        ex_is_ld = 1; ex_wen = 1; ex_rc = 5'd1;
        #2;
        n_rst = 0;
        #1;
        checks++; if (ex_valid !== 1'b0 || alu_fn !== 6'b010000 || ex_rc_o !== 5'd31) begin errors++; $display("FAIL mid_reset: got v=%0b fn=%b rc=%0d want 0 010000 31", ex_valid, alu_fn, ex_rc_o); end
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL mid_reset_stall: got %0b want 0", id_stall); end
        model_reset();
        @(posedge clk); #1;
        n_rst = 1;
        set_idle();
        if_valid = 1; if_instr = instr(6'b100000, 5'd2, 5'd1, {5'd2, 11'd0});
        step();
        checks++; if (alu_a !== 32'd0) begin errors++; $display("FAIL rf_cleared: got %h want 0", alu_a); end
    endtask

    task automatic test_random();
        logic [5:0] op;
        for (int n = 0; n < 400; n++) begin
            if_valid = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 4) != 0)
                op = {1'b1, 1'($urandom_range(0, 1)), fcodes[$urandom_range(0, 10)]};
            else
                op = 6'($urandom);
            if_instr = {op, pick_reg(), pick_reg(), pick_reg(), 11'($urandom)};
            if ($urandom_range(0, 3) == 0) if_instr[15] = 1'b1;
            ex_wen = 1'($urandom); ex_rc = pick_reg(); ex_y = $urandom;
            ex_is_ld = ($urandom_range(0, 3) == 0);
            mem_wen = 1'($urandom); mem_rc = pick_reg(); mem_y = $urandom;
            wb_wen = ($urandom_range(0, 4) < 3); wb_rc = pick_reg(); wb_y = $urandom;
            #1;
            predict();
            checks++; if (id_stall !== p_stall) begin errors++; $display("FAIL rnd_stall[%0d]: got %0b want %0b", n, id_stall, p_stall); end
            step();
            checks++; if (ex_valid !== e_valid || ex_wen_o !== e_wen) begin errors++; $display("FAIL rnd_ctl[%0d]: got %0b%0b want %0b%0b", n, ex_valid, ex_wen_o, e_valid, e_wen); end
            checks++; if (illegal !== e_illegal) begin errors++; $display("FAIL rnd_illegal[%0d]: got %0b want %0b", n, illegal, e_illegal); end
            checks++; if (alu_a !== e_a) begin errors++; $display("FAIL rnd_a[%0d]: got %h want %h", n, alu_a, e_a); end
            checks++; if (alu_b !== e_b) begin errors++; $display("FAIL rnd_b[%0d]: got %h want %h", n, alu_b, e_b); end
            checks++; if (alu_fn !== e_fn || ex_rc_o !== e_rc) begin errors++; $display("FAIL rnd_fn_rc[%0d]: got %b/%0d want %b/%0d", n, alu_fn, ex_rc_o, e_fn, e_rc); end
        end
    endtask

    initial begin
        test_reset();
        test_bypass_lit();
        test_ex_priority();
        test_load_use();
        test_r31();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
